// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-register sequence counter:
// mode encoding, per-mode seed state and per-mode sequence period.
package shift_seq_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    // Starting state for a mode; callers truncate to their own width.
    function automatic logic [MAX_W-1:0] seed(mode_t m);
        case (m)
            MODE_RING, MODE_LFSR: seed = MAX_W'(1);
            default:              seed = '0;
        endcase
    endfunction

    // Number of distinct states the mode walks through before repeating.
    // Reserved mode never steps; 1 keeps the phase arithmetic well defined.
    function automatic int period(mode_t m, int w);
        case (m)
            MODE_RING:    period = w;
            MODE_JOHNSON: period = 2 * w;
            MODE_LFSR:    period = (1 << w) - 1;
            default:      period = 1;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_counter_if.sv
// Control/status bundle of the sequence counter. The master drives the
// step controls and load value; the slave (the counter) returns state.
interface shift_seq_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] phase;
    logic             wrap;

    modport master (
        output en, dir, mode, load, load_val,
        input  count, phase, wrap
    );

    modport slave (
        input  en, dir, mode, load, load_val,
        output count, phase, wrap
    );
endinterface

// File: rtl/shift_seq_next.sv
// Combinational single-step function: given the current state, mode and
// direction, produce the state one step later. No priority or phase logic.
module shift_seq_next
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] count_i,
    input  mode_t            mode_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o
);

    logic fb_up;
    logic msb_dn;

    // Fibonacci feedback for the forward LFSR step. The reverse step
    // recovers the bit that fell off the MSB: the old LSB-bound feedback sits
    // in count_i[0], and the remaining tapped bits are now at positions +1.
    // This relies on TAPS[WIDTH-1] being set, true for any maximal mask.
    always_comb begin
        fb_up  = ^(count_i & TAPS);
        msb_dn = count_i[0] ^ (^(count_i[WIDTH-1:1] & TAPS[WIDTH-2:0]));
    end

    // Select the one-step successor for the active mode and direction.
    always_comb begin
        count_o = count_i;
        case (mode_i)
            MODE_RING: begin
                if (dir_i) count_o = {count_i[WIDTH-2:0], count_i[WIDTH-1]};
                else       count_o = {count_i[0], count_i[WIDTH-1:1]};
            end
            MODE_JOHNSON: begin
                if (dir_i) count_o = {count_i[WIDTH-2:0], ~count_i[WIDTH-1]};
                else       count_o = {~count_i[0], count_i[WIDTH-1:1]};
            end
            MODE_LFSR: begin
                if (dir_i) count_o = {count_i[WIDTH-2:0], fb_up};
                else       count_o = {msb_dn, count_i[WIDTH-1:1]};
            end
            default: count_o = count_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_counter.sv
// Run-time selectable ring / Johnson / LFSR sequence counter with up/down
// stepping, parallel load, step-index phase output and a wrap pulse.
// Edge priority: reset > load > mode change > step > hold.
// WIDTH must lie in 2..16 and TAPS must be a maximal-length mask.
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic                clk,
    input  logic                reset,
    shift_seq_counter_if.slave  bus
);

    mode_t            mode_in;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] per_m1;
    logic             lfsr_lock;

    assign mode_in = mode_t'(bus.mode);

    shift_seq_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .count_i (count_q),
        .mode_i  (mode_q),
        .dir_i   (bus.dir),
        .count_o (step_val)
    );

    // Last phase index of the running mode, and the LFSR lockup condition.
    always_comb begin
        per_m1    = WIDTH'(period(mode_q, WIDTH) - 1);
        lfsr_lock = (mode_q == MODE_LFSR) && (count_q == '0);
    end

    // Next-state selection for load, mode change and stepping; wrap is a
    // pulse, so it defaults low and is raised only by a boundary crossing.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        mode_d  = mode_q;
        if (bus.load) begin
            count_d = bus.load_val;
            phase_d = '0;
            mode_d  = mode_in;
        end else if (mode_in != mode_q) begin
            // A mode switch re-seeds and suppresses the step on this edge.
            count_d = WIDTH'(seed(mode_in));
            phase_d = '0;
            mode_d  = mode_in;
        end else if (bus.en && mode_q != MODE_RSVD) begin
            if (lfsr_lock) begin
                // Escape the all-zero LFSR state; not a wrap.
                count_d = WIDTH'(seed(MODE_LFSR));
                phase_d = '0;
            end else begin
                count_d = step_val;
                if (bus.dir) begin
                    if (phase_q == per_m1) begin
                        phase_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    if (phase_q == '0) begin
                        phase_d = per_m1;
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
            end
        end
    end

    // State registers; reset seeds from the mode presented on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= WIDTH'(seed(mode_in));
            phase_q <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= mode_in;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.count = count_q;
    assign bus.phase = phase_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Bench for shift_seq_counter (WIDTH=4, TAPS=4'b1100): each driven edge
// pushes its expected count/phase/wrap onto a scoreboard queue, which is
// popped and compared one time unit after the edge.
module tb_shift_seq_counter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    shift_seq_counter_if #(.WIDTH(4)) bus ();

    shift_seq_counter #(
        .WIDTH (4),
        .TAPS  (4'b1100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] c;
        logic [3:0] p;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Expected x^4+x^3+1 Fibonacci sequence from seed 0001, steps 1..15.
    logic [3:0] lfsr_tab [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                  4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] seen [15];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One edge: drive inputs, queue the expectation, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic l, input logic [3:0] lv,
                        input logic [1:0] m, input logic e, input logic d,
                        input logic [3:0] ec, input logic [3:0] ep, input logic ew);
        exp_t x;
        reset        = r;
        bus.load     = l;
        bus.load_val = lv;
        bus.mode     = m;
        bus.en       = e;
        bus.dir      = d;
        x.tag = tag; x.c = ec; x.p = ep; x.w = ew;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check_eq({x.tag, ".count"}, 32'(bus.count), 32'(x.c));
            check_eq({x.tag, ".phase"}, 32'(bus.phase), 32'(x.p));
            check_eq({x.tag, ".wrap"},  32'(bus.wrap),  32'(x.w));
        end
    endtask

    task automatic step_en(input string tag, input logic [1:0] m, input logic d,
                           input logic [3:0] ec, input logic [3:0] ep, input logic ew);
        step(tag, 1'b0, 1'b0, 4'h0, m, 1'b1, d, ec, ep, ew);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dups;
        bus.en = 1'b0; bus.dir = 1'b1; bus.mode = 2'b01; bus.load = 1'b0; bus.load_val = 4'h0;
        @(posedge clk); #1;

        // Reset in Johnson, then a full Johnson period upward.
        step("rst_j", 1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step_en("j1", 2'b01, 1'b1, 4'b0001, 4'd1, 1'b0);
        step_en("j2", 2'b01, 1'b1, 4'b0011, 4'd2, 1'b0);
        step_en("j3", 2'b01, 1'b1, 4'b0111, 4'd3, 1'b0);
        step_en("j4", 2'b01, 1'b1, 4'b1111, 4'd4, 1'b0);
        step_en("j5", 2'b01, 1'b1, 4'b1110, 4'd5, 1'b0);
        step_en("j6", 2'b01, 1'b1, 4'b1100, 4'd6, 1'b0);
        step_en("j7", 2'b01, 1'b1, 4'b1000, 4'd7, 1'b0);
        step_en("j8", 2'b01, 1'b1, 4'b0000, 4'd0, 1'b1);
        step("idle", 1'b0, 1'b0, 4'h0, 2'b01, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step_en("j_dn_wrap", 2'b01, 1'b0, 4'b1000, 4'd7, 1'b1);

        // Switch to ring with en high: re-seed, no step. Then up/down walk.
        step_en("to_ring", 2'b00, 1'b1, 4'b0001, 4'd0, 1'b0);
        step_en("r_up1", 2'b00, 1'b1, 4'b0010, 4'd1, 1'b0);
        step_en("r_up2", 2'b00, 1'b1, 4'b0100, 4'd2, 1'b0);
        step_en("r_up3", 2'b00, 1'b1, 4'b1000, 4'd3, 1'b0);
        step_en("r_dn1", 2'b00, 1'b0, 4'b0100, 4'd2, 1'b0);
        step_en("r_dn2", 2'b00, 1'b0, 4'b0010, 4'd1, 1'b0);
        step_en("r_dn3", 2'b00, 1'b0, 4'b0001, 4'd0, 1'b0);
        step_en("r_dn_wrap", 2'b00, 1'b0, 4'b1000, 4'd3, 1'b1);
        step_en("r_up_wrap", 2'b00, 1'b1, 4'b0001, 4'd0, 1'b1);

        // Johnson to state 0111, then switch to ring with en high.
        step_en("to_john", 2'b01, 1'b1, 4'b0000, 4'd0, 1'b0);
        step_en("jb1", 2'b01, 1'b1, 4'b0001, 4'd1, 1'b0);
        step_en("jb2", 2'b01, 1'b1, 4'b0011, 4'd2, 1'b0);
        step_en("jb3", 2'b01, 1'b1, 4'b0111, 4'd3, 1'b0);
        step_en("j_to_ring", 2'b00, 1'b1, 4'b0001, 4'd0, 1'b0);

        // Reserved mode: seed 0, load accepted, stepping holds.
        step_en("to_rsvd", 2'b11, 1'b1, 4'b0000, 4'd0, 1'b0);
        step("rsvd_load", 1'b0, 1'b1, 4'b1010, 2'b11, 1'b0, 1'b1, 4'b1010, 4'd0, 1'b0);
        step_en("rsvd_hold", 2'b11, 1'b1, 4'b1010, 4'd0, 1'b0);

        // LFSR full period from seed, then one reverse step.
        step_en("to_lfsr", 2'b10, 1'b1, 4'b0001, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step_en($sformatf("lfsr%0d", i + 1), 2'b10, 1'b1, lfsr_tab[i],
                    (i == 14) ? 4'd0 : 4'(i + 1), (i == 14));
            seen[i] = bus.count;
        end
        dups = 0;
        for (int i = 0; i < 15; i++) begin
            if (seen[i] == 4'b0000) dups++;
            for (int j = i + 1; j < 15; j++)
                if (seen[i] == seen[j]) dups++;
        end
        check_eq("lfsr_distinct", 32'(dups), 32'd0);
        step_en("lfsr_dn", 2'b10, 1'b0, 4'b1000, 4'd14, 1'b1);
        step_en("lfsr_up_again", 2'b10, 1'b1, 4'b0001, 4'd0, 1'b1);
        step("lfsr_idle", 1'b0, 1'b0, 4'h0, 2'b10, 1'b0, 1'b1, 4'b0001, 4'd0, 1'b0);

        // Load all-zero into LFSR and escape lockup.
        step("lock_load", 1'b0, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
        step_en("lock_escape", 2'b10, 1'b1, 4'b0001, 4'd0, 1'b0);
        step_en("lock_next", 2'b10, 1'b1, 4'b0010, 4'd1, 1'b0);

        // Priority checks.
        step("pri_rst", 1'b1, 1'b1, 4'b0110, 2'b10, 1'b1, 1'b1, 4'b0001, 4'd0, 1'b0);
        step_en("pri_step", 2'b10, 1'b1, 4'b0010, 4'd1, 1'b0);
        step("pri_load", 1'b0, 1'b1, 4'b0110, 2'b10, 1'b1, 1'b1, 4'b0110, 4'd0, 1'b0);
        step("pri_rst_mode", 1'b1, 1'b0, 4'h0, 2'b01, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
